// File: rtl/repeated_pattern_extractor_pkg.sv
// Shared definitions for the mask-row pattern extractor.
//   IMG_W    : sensor row width in bits
//   PMAX     : largest horizontal period searched (must be <= 15)
//   VCNT_W   : vertical run counter width
//   state_t  : extractor FSM states
//   rp_desc_t: compact run descriptor {period, pattern, hrepeat, vrepeat}
//   ceil_div : ceiling division, used to size hrepeat per period
package mask_pkg;

    localparam int IMG_W  = 300;
    localparam int PMAX   = 8;
    localparam int VCNT_W = 11;

    typedef enum logic [1:0] {IDLE, SCAN, EVAL, EMIT} state_t;

    typedef struct packed {
        logic [3:0]        period;   // 0 = aperiodic
        logic [PMAX-1:0]   pattern;
        logic [8:0]        hrepeat;
        logic [VCNT_W-1:0] vrepeat;
    } rp_desc_t;

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/repeated_pattern_extractor_period_match.sv
// Combinational period test for one candidate.
//   row   : full mask row, bit 0 = column 0
//   cand  : candidate period (1..PMAX; other values never match)
//   match : row[i] == row[i mod cand] for every column i
// row[i]==row[i mod c] for all i is the same as row[i]==row[i-c] for all i>=c,
// so each candidate reduces to comparing the row against itself shifted by c.
// The per-candidate comparators use fixed slices; cand only drives a mux.
module period_match
    import mask_pkg::*;
(
    input  logic [IMG_W-1:0] row,
    input  logic [3:0]       cand,
    output logic             match
);

    logic [15:0] m;

    assign m[0] = 1'b0;

    for (genvar c = 1; c < 16; c++) begin : g_cand
        if (c <= PMAX) begin : g_cmp
            assign m[c] = (row[IMG_W-1:c] == row[IMG_W-1-c:0]);
        end else begin : g_off
            assign m[c] = 1'b0;
        end
    end

    assign match = m[cand];

endmodule

// File: rtl/repeated_pattern_extractor.sv
// Repeated pattern extractor: finds each row's smallest horizontal period,
// merges runs of identical rows and emits one descriptor per run.
//   clk, rst_n    : clock, asynchronous active-low reset
//   clk_en        : clock enable; low freezes all state and blocks handshakes
//   row_valid/row_ready/row_data/row_last : input row stream
//   desc_valid/desc_ready                 : descriptor handshake
//   desc_period/pattern/hrepeat/vrepeat   : descriptor of the held run
//   desc_last     : final descriptor of the frame
module repeated_pattern_extractor
    import mask_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_en,
    input  logic              row_valid,
    output logic              row_ready,
    input  logic [IMG_W-1:0]  row_data,
    input  logic              row_last,
    output logic              desc_valid,
    input  logic              desc_ready,
    output logic [3:0]        desc_period,
    output logic [PMAX-1:0]   desc_pattern,
    output logic [8:0]        desc_hrepeat,
    output logic [VCNT_W-1:0] desc_vrepeat,
    output logic              desc_last
);

    state_t           state, state_n;
    logic [IMG_W-1:0] row_q;
    logic             last_f;
    logic [3:0]       cand;
    logic [3:0]       per_q;
    rp_desc_t         hold, pend, n_desc;
    logic             hold_v, pend_v;
    logic             cand_match;
    logic             accept, desc_fire, merge, scan_done;
    logic [PMAX-1:0]  pat_mask;

    // Single comparator shared across all candidates, one per SCAN cycle.
    period_match u_match (
        .row   (row_q),
        .cand  (cand),
        .match (cand_match)
    );

    assign row_ready  = rst_n & clk_en & (state == IDLE);
    assign desc_valid = clk_en & (state == EMIT);
    assign accept     = row_valid & row_ready;
    assign desc_fire  = desc_valid & desc_ready;
    assign scan_done  = cand_match | (cand == 4'(PMAX));

    assign desc_period  = hold.period;
    assign desc_pattern = hold.pattern;
    assign desc_hrepeat = hold.hrepeat;
    assign desc_vrepeat = hold.vrepeat;
    // The pending descriptor (if any) goes out after the held one, so only
    // the last one presented carries the frame end.
    assign desc_last    = (state == EMIT) & last_f & ~pend_v;

    // New descriptor from the scanned row.
    always_comb begin
        for (int b = 0; b < PMAX; b++) begin
            pat_mask[b] = (4'(b) < per_q);
        end
        n_desc         = '0;
        n_desc.period  = per_q;
        n_desc.vrepeat = VCNT_W'(1);
        n_desc.pattern = (per_q == 4'd0) ? row_q[PMAX-1:0] : (row_q[PMAX-1:0] & pat_mask);
        for (int p = 1; p <= PMAX; p++) begin
            if (per_q == 4'(p)) n_desc.hrepeat = 9'(ceil_div(IMG_W, p));
        end
    end

    // Same period and pattern means an identical row; aperiodic rows never
    // merge, and a saturated run starts a fresh descriptor instead of wrapping.
    assign merge = hold_v && (n_desc.period != 4'd0) &&
                   (n_desc.period == hold.period) &&
                   (n_desc.pattern == hold.pattern) &&
                   (hold.vrepeat != {VCNT_W{1'b1}});

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept) state_n = SCAN;
            SCAN: if (scan_done) state_n = EVAL;
            EVAL: begin
                if (merge)       state_n = last_f ? EMIT : IDLE;
                else if (hold_v) state_n = EMIT;
                else             state_n = last_f ? EMIT : IDLE;
            end
            EMIT: if (desc_fire) state_n = (pend_v && last_f) ? EMIT : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      state <= IDLE;
        else if (clk_en) state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q  <= '0;
            last_f <= 1'b0;
            cand   <= 4'd0;
            per_q  <= 4'd0;
            hold   <= '0;
            pend   <= '0;
            hold_v <= 1'b0;
            pend_v <= 1'b0;
        end else if (clk_en) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        row_q  <= row_data;
                        last_f <= row_last;
                        cand   <= 4'd1;
                    end
                end
                SCAN: begin
                    if (cand_match)               per_q <= cand;
                    else if (cand == 4'(PMAX))    per_q <= 4'd0;
                    else                          cand  <= cand + 4'd1;
                end
                EVAL: begin
                    if (merge) begin
                        hold.vrepeat <= hold.vrepeat + VCNT_W'(1);
                    end else if (hold_v) begin
                        pend   <= n_desc;
                        pend_v <= 1'b1;
                    end else begin
                        hold   <= n_desc;
                        hold_v <= 1'b1;
                    end
                end
                EMIT: begin
                    if (desc_fire) begin
                        if (pend_v) begin
                            hold   <= pend;
                            pend_v <= 1'b0;
                        end else begin
                            hold_v <= 1'b0;
                            last_f <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_repeated_pattern_extractor.sv
module tb_repeated_pattern_extractor;
    import mask_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clk_en = 1'b1;
    logic              row_valid = 1'b0;
    logic              row_ready;
    logic [IMG_W-1:0]  row_data = '0;
    logic              row_last = 1'b0;
    logic              desc_valid;
    logic              desc_ready = 1'b0;
    logic [3:0]        desc_period;
    logic [PMAX-1:0]   desc_pattern;
    logic [8:0]        desc_hrepeat;
    logic [VCNT_W-1:0] desc_vrepeat;
    logic              desc_last;

    repeated_pattern_extractor dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data), .row_last(row_last),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_period(desc_period), .desc_pattern(desc_pattern), .desc_hrepeat(desc_hrepeat),
        .desc_vrepeat(desc_vrepeat), .desc_last(desc_last)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    longint      cyc = 0;
    logic [32:0] exp_q[$];
    bit          use_model = 1'b0;
    int          rdy_mode = 2;   // 0 random, 1 hold low, 2 hold high
    bit          lat_armed = 1'b0;
    longint      lat_exp = 0;
    longint      acc_edge = 0;
    bit          prev_valid = 1'b0, prev_ready = 1'b0;
    logic [32:0] prev_desc = '0;
    logic [32:0] cur;

    // reference run state
    bit run_v = 1'b0;
    int run_per, run_pat, run_hrep, run_vrep;

    assign cur = {desc_period, desc_pattern, desc_hrepeat, desc_vrepeat, desc_last};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", nm, act, exp);
    endtask

    function automatic logic [32:0] pk(input int per, input int pat, input int hrep,
                                       input int vrep, input bit last);
        logic [31:0] a, b, c, d;
        a = per; b = pat; c = hrep; d = vrep;
        return {a[3:0], b[PMAX-1:0], c[8:0], d[VCNT_W-1:0], last};
    endfunction

    function automatic logic [IMG_W-1:0] rep(input logic [14:0] pat, input int p);
        logic [IMG_W-1:0] r;
        for (int i = 0; i < IMG_W; i++) r[i] = pat[i % p];
        return r;
    endfunction

    // Smallest period by the definition: row[i]==row[i mod c] for every column.
    function automatic int ref_period(input logic [IMG_W-1:0] r);
        for (int c = 1; c <= PMAX; c++) begin
            bit ok = 1'b1;
            for (int i = 0; i < IMG_W; i++) if (r[i] != r[i % c]) ok = 1'b0;
            if (ok) return c;
        end
        return 0;
    endfunction

    task automatic model_accept(input logic [IMG_W-1:0] r, input bit last);
        int p, pat, hrep;
        p    = ref_period(r);
        pat  = (p == 0) ? int'(r[PMAX-1:0]) : int'(r[PMAX-1:0]) % (1 << p);
        hrep = (p == 0) ? 0 : (IMG_W + p - 1) / p;
        if (run_v && p != 0 && p == run_per && pat == run_pat && run_vrep < (1 << VCNT_W) - 1) begin
            run_vrep++;
        end else begin
            if (run_v) exp_q.push_back(pk(run_per, run_pat, run_hrep, run_vrep, 1'b0));
            run_v = 1'b1; run_per = p; run_pat = pat; run_hrep = hrep; run_vrep = 1;
        end
        if (last) begin
            exp_q.push_back(pk(run_per, run_pat, run_hrep, run_vrep, 1'b1));
            run_v = 1'b0;
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       desc_ready = 1'($urandom_range(0, 1));
            1:       desc_ready = 1'b0;
            default: desc_ready = 1'b1;
        endcase
    end

    // Acceptance watcher + descriptor monitor (handshakes land on the next posedge).
    always @(negedge clk) begin
        if (rst_n) begin
            if (row_valid && row_ready && clk_en) begin
                acc_edge = cyc + 1;
                if (use_model) model_accept(row_data, row_last);
            end
            if (desc_valid) begin
                if (lat_armed && !prev_valid) begin
                    chk("latency", 64'(cyc - acc_edge), 64'(lat_exp));
                    lat_armed = 1'b0;
                end
                if (prev_valid && !prev_ready) chk("stall_stable", cur, prev_desc);
                chk("row_ready_in_emit", row_ready, 0);
                if (desc_ready) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected_desc: got %0h required none", cur);
                    end else begin
                        chk("desc", cur, exp_q.pop_front());
                    end
                end
            end
            prev_valid = desc_valid; prev_ready = desc_ready; prev_desc = cur;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic send_row(input logic [IMG_W-1:0] r, input bit last);
        int  t = 0;
        bit  done = 1'b0;
        @(posedge clk); #1;
        row_data = r; row_last = last; row_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (row_ready && clk_en) done = 1'b1;
            else if (++t > 500) begin
                n_chk++;
                $display("FAIL row_accept_timeout: got no accept required accept");
                done = 1'b1;
            end
        end
        @(posedge clk); #1;
        row_valid = 1'b0; row_last = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(negedge clk); t++;
        end
        chk("drain_remaining", exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IMG_W-1:0] r, prev_r;
        logic [IMG_W-1:0] one;
        one = '0; one[0] = 1'b1;

        // reset values
        repeat (3) @(posedge clk);
        #2;
        chk("rst_row_ready", row_ready, 0);
        chk("rst_desc_valid", desc_valid, 0);
        chk("rst_desc_fields", cur, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("idle_row_ready", row_ready, 1);

        // directed frames with hand-derived expectations
        rdy_mode = 2; use_model = 1'b0;
        exp_q.push_back(pk(4, 8'h08, 75, 1, 1'b1));
        lat_exp = 5; lat_armed = 1'b1;   // SCAN 4 + EVAL 1
        send_row(rep(15'b1000, 4), 1'b1);
        drain();

        exp_q.push_back(pk(2, 8'h02, 150, 3, 1'b0));
        exp_q.push_back(pk(1, 8'h01, 300, 1, 1'b1));
        repeat (3) send_row(rep(15'b10, 2), 1'b0);
        send_row('1, 1'b1);
        drain();

        exp_q.push_back(pk(0, 8'h00, 0, 1, 1'b1));
        lat_exp = 9; lat_armed = 1'b1;   // SCAN 8 + EVAL 1
        send_row(one << (IMG_W - 1), 1'b1);
        drain();

        exp_q.push_back(pk(7, 8'h05, 43, 1, 1'b1));
        send_row(rep(15'b0000101, 7), 1'b1);
        drain();

        // consumer stall with a row waiting behind it
        use_model = 1'b1; rdy_mode = 1;
        send_row(rep(15'b011, 3), 1'b0);
        send_row(rep(15'b00111, 5), 1'b1);
        fork
            send_row(rep(15'b01, 2), 1'b1);
            begin
                int t = 0;
                while (!desc_valid && t < 100) begin @(negedge clk); t++; end
                chk("stall_reached_emit", desc_valid, 1);
                repeat (10) begin
                    @(negedge clk);
                    chk("stall_valid_held", desc_valid, 1);
                end
                rdy_mode = 2;
            end
        join
        drain();

        // clock enable low mid-SCAN
        send_row(rep(15'b10011, 5), 1'b1);
        @(posedge clk); #1;
        clk_en = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("clken_row_ready", row_ready, 0);
            chk("clken_desc_valid", desc_valid, 0);
        end
        @(posedge clk); #1;
        clk_en = 1'b1;
        drain();

        // reset mid-SCAN after two identical rows discards the run
        rdy_mode = 0;
        send_row(rep(15'b01, 2), 1'b0);
        send_row(rep(15'b01, 2), 1'b0);
        #3;
        rst_n = 1'b0;
        run_v = 1'b0;
        #1;
        chk("midrst_row_ready", row_ready, 0);
        chk("midrst_desc_valid", desc_valid, 0);
        chk("midrst_desc_fields", cur, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_idle_ready", row_ready, 1);
        send_row(rep(15'b01, 2), 1'b1);
        drain();

        // randomized frames
        prev_r = rep(15'b1, 1);
        for (int f = 0; f < 40; f++) begin
            int nrows = $urandom_range(1, 5);
            for (int k = 0; k < nrows; k++) begin
                if ($urandom_range(0, 1) == 0) begin
                    r = prev_r;
                end else begin
                    int p = $urandom_range(0, PMAX);
                    if (p == 0) begin
                        for (int w = 0; w < IMG_W; w++) r[w] = 1'($urandom_range(0, 1));
                    end else begin
                        r = rep(15'($urandom), p);
                    end
                end
                prev_r = r;
                send_row(r, k == nrows - 1);
            end
        end
        drain();

        // vertical counter saturation starts a new run
        rdy_mode = 2;
        for (int k = 0; k < 2048; k++) send_row('0, k == 2047);
        drain();

        chk("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
